// File: rtl/uart_defs_pkg.sv
// Shared UART types: TX state encoding, line config, parity helper.
// Used by both the TX serializer and the RX deserializer.
package uart_defs;

  localparam int CFG_DIV_W  = 16;
  localparam int CFG_DATA_W = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_REQ,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } TxState_t;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] baud_div;
    logic [1:0]           data_bits;
    logic                 parity_en;
    logic                 parity_odd;
    logic                 stop2;
  } Config_t;

  // Only the low 5..8 bits selected by data_bits take part.
  function automatic logic frame_parity(
    input logic [CFG_DATA_W-1:0] d,
    input logic [1:0]            bits,
    input logic                  odd
  );
    logic [CFG_DATA_W-1:0] m;
    m = d;
    if (bits < 2'd3) m[7] = 1'b0;
    if (bits < 2'd2) m[6] = 1'b0;
    if (bits < 2'd1) m[5] = 1'b0;
    return (^m) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator; a period of 0 behaves as 1.
// Counter restarts on clear so a frame always begins on a full period.
module uart_baud_gen #(
  parameter int W = 16
) (
  input  logic         tck,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] period_i,
  output logic         tick_o
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_last;

  assign w_last = (period_i == '0) ? '0 : period_i - W'(1);
  assign tick_o = enable_i & (r_cnt == w_last);

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (enable_i) begin
      r_cnt <= tick_o ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit datapath: one-entry holding register, RTS/CTS request,
// and frame serializer (start, 5-8 data LSB-first, parity, 1-2 stops).
module uart_tx_serializer
  import uart_defs::*;
#(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              tck,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_rts_n_o,
  input  logic              tx_cts_n_i,
  input  logic              tx_enable_i,
  output logic              txd_o,
  output logic              busy_o,
  input  Config_t           uart_config_i
);

  TxState_t          r_state;
  TxState_t          w_next;
  logic              r_full;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_d;
  logic [DIV_W-1:0]  r_period;
  logic [1:0]        r_bits;
  logic              r_par_en;
  logic              r_stop2;
  logic              r_par;
  logic [2:0]        r_bitcnt;
  logic              r_stopcnt;
  logic              r_txd;
  logic              r_rts_n;
  logic              r_busy;
  logic              w_tick;
  logic              w_start;
  logic              w_load;
  logic              w_full_d;
  logic              w_txd_d;
  logic              w_last_bit;
  logic              w_stop_end;
  logic              w_baud_en;

  assign w_load     = valid_i & ~r_full;
  assign w_start    = (w_next == TX_START) & (r_state != TX_START);
  assign w_last_bit = (r_bitcnt == {1'b1, r_bits});
  assign w_stop_end = w_tick & (~r_stop2 | r_stopcnt);
  assign w_baud_en  = (r_state != TX_IDLE) & (r_state != TX_REQ);
  assign w_full_d   = w_start ? 1'b0 : (r_full | w_load);

  uart_baud_gen #(.W(DIV_W)) u_baud (
    .tck      (tck),
    .rst_n    (rst_n),
    .clear_i  (w_start),
    .enable_i (w_baud_en),
    .period_i (r_period),
    .tick_o   (w_tick)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      TX_IDLE: begin
        if (r_full & tx_enable_i) w_next = TX_REQ;
      end
      TX_REQ: begin
        if (!tx_enable_i)     w_next = TX_IDLE;
        else if (!tx_cts_n_i) w_next = TX_START;
      end
      TX_START: begin
        if (w_tick) w_next = TX_DATA;
      end
      TX_DATA: begin
        if (w_tick & w_last_bit)
          w_next = r_par_en ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        if (w_tick) w_next = TX_STOP;
      end
      TX_STOP: begin
        // Back-to-back frames skip REQ while CTS stays granted.
        if (w_stop_end) begin
          if (r_full & tx_enable_i)
            w_next = tx_cts_n_i ? TX_REQ : TX_START;
          else
            w_next = TX_IDLE;
        end
      end
      default: w_next = TX_IDLE;
    endcase
  end

  always_comb begin
    w_shift_d = r_shift;
    if (w_start)
      w_shift_d = r_hold;
    else if ((r_state == TX_DATA) & w_tick)
      w_shift_d = r_shift >> 1;
  end

  always_comb begin
    w_txd_d = 1'b1;
    unique case (w_next)
      TX_START:  w_txd_d = 1'b0;
      TX_DATA:   w_txd_d = w_shift_d[0];
      TX_PARITY: w_txd_d = r_par;
      default:   w_txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= TX_IDLE;
      r_full    <= 1'b0;
      r_hold    <= '0;
      r_shift   <= '0;
      r_period  <= '0;
      r_bits    <= '0;
      r_par_en  <= 1'b0;
      r_stop2   <= 1'b0;
      r_par     <= 1'b0;
      r_bitcnt  <= '0;
      r_stopcnt <= 1'b0;
      r_txd     <= 1'b1;
      r_rts_n   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_full  <= w_full_d;
      r_shift <= w_shift_d;
      r_txd   <= w_txd_d;
      r_rts_n <= (w_next == TX_IDLE);
      r_busy  <= (w_next != TX_IDLE) | w_full_d;
      if (w_load) r_hold <= data_i;
      if (w_start) begin
        r_period <= uart_config_i.baud_div;
        r_bits   <= uart_config_i.data_bits;
        r_par_en <= uart_config_i.parity_en;
        r_stop2  <= uart_config_i.stop2;
        r_par    <= frame_parity(r_hold,
                                 uart_config_i.data_bits,
                                 uart_config_i.parity_odd);
        r_bitcnt <= '0;
      end else if ((r_state == TX_DATA) & w_tick) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (r_state != TX_STOP) r_stopcnt <= 1'b0;
      else if (w_tick)        r_stopcnt <= 1'b1;
    end
  end

  assign ready_o    = ~r_full;
  assign tx_rts_n_o = r_rts_n;
  assign txd_o      = r_txd;
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frames, parity, flow control,
// enable gating and asynchronous reset, checked on the falling edge.
module tb_uart_tx_serializer;
  import uart_defs::*;

  logic       tck = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       tx_rts_n_o;
  logic       tx_cts_n_i = 1'b0;
  logic       tx_enable_i = 1'b1;
  logic       txd_o;
  logic       busy_o;
  Config_t    cfg;

  int errs = 0;
  int checks = 0;

  always #5 tck = ~tck;

  uart_tx_serializer dut (
    .tck           (tck),
    .rst_n         (rst_n),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .tx_rts_n_o    (tx_rts_n_o),
    .tx_cts_n_i    (tx_cts_n_i),
    .tx_enable_i   (tx_enable_i),
    .txd_o         (txd_o),
    .busy_o        (busy_o),
    .uart_config_i (cfg)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [1:0] bits,
                         input logic pe, input logic po, input logic s2);
    cfg.baud_div   = div;
    cfg.data_bits  = bits;
    cfg.parity_en  = pe;
    cfg.parity_odd = po;
    cfg.stop2      = s2;
  endtask

  task automatic send(input logic [7:0] b);
    data_i  = b;
    valid_i = 1'b1;
    @(negedge tck);
    valid_i = 1'b0;
  endtask

  // bits[k] is the expected line level of bit slot k (slot 0 = start).
  task automatic frame(input string tag, input logic [15:0] bits,
                       input int n, input int p, input int skip,
                       input int cts_at);
    for (int i = skip; i < n * p; i++) begin
      chk(tag, txd_o, bits[i / p]);
      chk({tag, "_rts"}, tx_rts_n_o, 1'b0);
      if (i == cts_at) tx_cts_n_i = 1'b1;
      @(negedge tck);
    end
  endtask

  initial begin
    set_cfg(16'd4, 2'd3, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge tck);
    chk("rst_txd", txd_o, 1'b1);
    chk("rst_rts", tx_rts_n_o, 1'b1);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    @(negedge tck);

    // 8N1, div 4, 0xA5
    send(8'hA5);
    chk("a5_ready0", ready_o, 1'b0);
    chk("a5_rts_wait", tx_rts_n_o, 1'b1);
    chk("a5_busy", busy_o, 1'b1);
    @(negedge tck);
    chk("a5_rts_req", tx_rts_n_o, 1'b0);
    chk("a5_txd_req", txd_o, 1'b1);
    @(negedge tck);
    chk("a5_ready1", ready_o, 1'b1);
    frame("a5", 16'h034A, 10, 4, 0, -1);
    chk("a5_rts_end", tx_rts_n_o, 1'b1);
    chk("a5_busy_end", busy_o, 1'b0);
    chk("a5_txd_end", txd_o, 1'b1);

    // 7E1, div 2, 0x07
    set_cfg(16'd2, 2'd2, 1'b1, 1'b0, 1'b0);
    send(8'h07);
    @(negedge tck);
    @(negedge tck);
    frame("7e1", 16'h030E, 10, 2, 0, -1);
    chk("7e1_rts_end", tx_rts_n_o, 1'b1);

    // 7O1, div 0 (acts as 1), 0x07
    set_cfg(16'd0, 2'd2, 1'b1, 1'b1, 1'b0);
    send(8'h07);
    @(negedge tck);
    @(negedge tck);
    frame("7o1", 16'h020E, 10, 1, 0, -1);
    chk("7o1_rts_end", tx_rts_n_o, 1'b1);

    // 8N2, div 2, back-to-back 0x3C then 0xC3
    set_cfg(16'd2, 2'd3, 1'b0, 1'b0, 1'b1);
    send(8'h3C);
    @(negedge tck);
    @(negedge tck);
    chk("b2b_ready_start", ready_o, 1'b1);
    chk("b2b_txd_start", txd_o, 1'b0);
    data_i  = 8'hC3;
    valid_i = 1'b1;
    @(negedge tck);
    valid_i = 1'b0;
    chk("b2b_ready_full", ready_o, 1'b0);
    frame("b2b_1", 16'h0678, 11, 2, 1, -1);
    chk("b2b_ready_2nd", ready_o, 1'b1);
    frame("b2b_2", 16'h0786, 11, 2, 0, -1);
    chk("b2b_rts_end", tx_rts_n_o, 1'b1);
    chk("b2b_busy_end", busy_o, 1'b0);

    // CTS held high for 20 cycles after request
    set_cfg(16'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    tx_cts_n_i = 1'b1;
    send(8'h5A);
    @(negedge tck);
    for (int i = 0; i < 20; i++) begin
      chk("cts_hold_txd", txd_o, 1'b1);
      chk("cts_hold_rts", tx_rts_n_o, 1'b0);
      @(negedge tck);
    end
    tx_cts_n_i = 1'b0;
    @(negedge tck);
    frame("cts", 16'h02B4, 10, 1, 0, -1);
    chk("cts_rts_end", tx_rts_n_o, 1'b1);

    // CTS raised mid-DATA with a second byte pending
    set_cfg(16'd2, 2'd3, 1'b0, 1'b0, 1'b0);
    send(8'h01);
    @(negedge tck);
    @(negedge tck);
    data_i  = 8'h80;
    valid_i = 1'b1;
    @(negedge tck);
    valid_i = 1'b0;
    frame("mid1", 16'h0202, 10, 2, 1, 8);
    for (int i = 0; i < 5; i++) begin
      chk("mid_req_txd", txd_o, 1'b1);
      chk("mid_req_rts", tx_rts_n_o, 1'b0);
      chk("mid_req_busy", busy_o, 1'b1);
      @(negedge tck);
    end
    tx_cts_n_i = 1'b0;
    @(negedge tck);
    frame("mid2", 16'h0300, 10, 2, 0, -1);
    chk("mid_rts_end", tx_rts_n_o, 1'b1);
    chk("mid_busy_end", busy_o, 1'b0);

    // Enable low holds the byte; then reset mid-DATA
    set_cfg(16'd4, 2'd3, 1'b0, 1'b0, 1'b0);
    tx_enable_i = 1'b0;
    send(8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("en_rts", tx_rts_n_o, 1'b1);
      chk("en_txd", txd_o, 1'b1);
      chk("en_busy", busy_o, 1'b1);
      chk("en_ready", ready_o, 1'b0);
      @(negedge tck);
    end
    tx_enable_i = 1'b1;
    @(negedge tck);
    chk("en_rts_req", tx_rts_n_o, 1'b0);
    @(negedge tck);
    chk("en_txd_start", txd_o, 1'b0);
    data_i  = 8'hFF;
    valid_i = 1'b1;
    @(negedge tck);
    valid_i = 1'b0;
    chk("en_ready_full", ready_o, 1'b0);
    repeat (8) @(negedge tck);
    chk("pre_rst_txd", txd_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_txd", txd_o, 1'b1);
    chk("arst_rts", tx_rts_n_o, 1'b1);
    chk("arst_ready", ready_o, 1'b1);
    chk("arst_busy", busy_o, 1'b0);
    @(negedge tck);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge tck);
      chk("post_rst_rts", tx_rts_n_o, 1'b1);
      chk("post_rst_txd", txd_o, 1'b1);
      chk("post_rst_busy", busy_o, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
